// File: rtl/branch_predictor_if.sv
`default_nettype none
// ============================================================================
// Interface : branch_predictor_if
// Purpose   : Fetch-side query and decode-side training bundle for the predictor.
// Revision  : 1.0 - initial release
// ============================================================================
interface branch_predictor_if;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [1:0]  upd_kind;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_link;

  modport master (
    output if_pc, upd_valid, upd_pc, upd_kind, upd_taken, upd_target, upd_link,
    input  pred_taken, pred_target
  );

  modport slave (
    input  if_pc, upd_valid, upd_pc, upd_kind, upd_taken, upd_target, upd_link,
    output pred_taken, pred_target
  );
endinterface
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor
// Purpose  : Direct-mapped BTB with 2-bit counters plus a non-speculative
//            return address stack; predicts the next fetch PC.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_WIDTH  = 8,
  parameter int RAS_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  branch_predictor_if.slave bp
);

  localparam int                     c_entries   = 1 << INDEX_BITS;
  localparam int                     c_ras_ptr_w = $clog2(RAS_DEPTH);
  localparam logic [c_ras_ptr_w:0]   c_ras_full  = (c_ras_ptr_w+1)'(RAS_DEPTH);
  localparam logic [c_ras_ptr_w-1:0] c_ptr_one   = c_ras_ptr_w'(1);
  localparam logic [c_ras_ptr_w:0]   c_cnt_one   = (c_ras_ptr_w+1)'(1);
  localparam logic [1:0]             c_kind_cond = 2'd0;
  localparam logic [1:0]             c_kind_ret  = 2'd3;

  // BTB storage: valid and counters are reset, payload fields are not
  logic [c_entries-1:0] r_valid;
  logic [1:0]           r_ctr    [c_entries];
  logic [TAG_WIDTH-1:0] r_tag    [c_entries];
  logic [1:0]           r_kind   [c_entries];
  logic [31:0]          r_target [c_entries];

  logic [31:0]            r_ras [RAS_DEPTH];
  logic [c_ras_ptr_w-1:0] r_ras_top;
  logic [c_ras_ptr_w:0]   r_ras_cnt;

  logic [INDEX_BITS-1:0]  w_lidx;
  logic [TAG_WIDTH-1:0]   w_ltag;
  logic                   w_lhit;
  logic                   w_ltaken;
  logic [31:0]            w_pred_target;
  logic                   w_ras_nonempty;

  logic [INDEX_BITS-1:0]  w_uidx;
  logic [TAG_WIDTH-1:0]   w_utag;
  logic                   w_uhit;
  logic                   w_alloc;
  logic                   w_entry_we;
  logic                   w_tgt_we;
  logic [1:0]             w_ctr_old;
  logic [1:0]             w_ctr_next;

  logic                   w_push;
  logic                   w_pop;
  logic [31:0]            w_link_addr;
  logic                   w_ras_we;
  logic [c_ras_ptr_w-1:0] w_ras_waddr;
  logic [c_ras_ptr_w-1:0] w_ras_top_next;
  logic [c_ras_ptr_w:0]   w_ras_cnt_next;

  // --------------------------------------------------------------------------
  // Lookup: purely from registered state, so same-cycle training is not seen
  // --------------------------------------------------------------------------
  assign w_lidx         = bp.if_pc[INDEX_BITS+1:2];
  assign w_ltag         = bp.if_pc[INDEX_BITS+2 +: TAG_WIDTH];
  assign w_lhit         = r_valid[w_lidx] && (r_tag[w_lidx] == w_ltag);
  assign w_ltaken       = w_lhit && ((r_kind[w_lidx] != c_kind_cond) || r_ctr[w_lidx][1]);
  assign w_ras_nonempty = (r_ras_cnt != '0);

  always_comb begin
    w_pred_target = bp.if_pc + 32'd4;
    if (w_ltaken) begin
      if ((r_kind[w_lidx] == c_kind_ret) && w_ras_nonempty) begin
        w_pred_target = r_ras[r_ras_top];
      end else begin
        w_pred_target = r_target[w_lidx];
      end
    end
  end

  assign bp.pred_taken  = w_ltaken;
  assign bp.pred_target = w_pred_target;

  // --------------------------------------------------------------------------
  // Training
  // --------------------------------------------------------------------------
  assign w_uidx     = bp.upd_pc[INDEX_BITS+1:2];
  assign w_utag     = bp.upd_pc[INDEX_BITS+2 +: TAG_WIDTH];
  assign w_uhit     = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
  assign w_alloc    = !w_uhit && (bp.upd_taken || (bp.upd_kind != c_kind_cond));
  assign w_entry_we = bp.upd_valid && (w_uhit || w_alloc);
  // Not-taken conditional hits keep their old target
  assign w_tgt_we   = w_entry_we && (bp.upd_taken || (bp.upd_kind != c_kind_cond));
  assign w_ctr_old  = r_ctr[w_uidx];

  always_comb begin
    w_ctr_next = 2'b11;
    if (bp.upd_kind == c_kind_cond) begin
      if (w_alloc) begin
        w_ctr_next = 2'b10;
      end else if (bp.upd_taken) begin
        w_ctr_next = (w_ctr_old == 2'b11) ? 2'b11 : w_ctr_old + 2'b01;
      end else begin
        w_ctr_next = (w_ctr_old == 2'b00) ? 2'b00 : w_ctr_old - 2'b01;
      end
    end
  end

  assign w_push      = bp.upd_valid && bp.upd_link;
  assign w_pop       = bp.upd_valid && (bp.upd_kind == c_kind_ret);
  assign w_link_addr = bp.upd_pc + 32'd8;

  // Full stack pushes wrap onto the oldest slot; empty pops are dropped
  always_comb begin
    w_ras_we       = 1'b0;
    w_ras_waddr    = r_ras_top;
    w_ras_top_next = r_ras_top;
    w_ras_cnt_next = r_ras_cnt;
    if (w_push && w_pop) begin
      w_ras_we = 1'b1;
    end else if (w_push) begin
      w_ras_we       = 1'b1;
      w_ras_waddr    = r_ras_top + c_ptr_one;
      w_ras_top_next = r_ras_top + c_ptr_one;
      if (r_ras_cnt != c_ras_full) begin
        w_ras_cnt_next = r_ras_cnt + c_cnt_one;
      end
    end else if (w_pop && w_ras_nonempty) begin
      w_ras_top_next = r_ras_top - c_ptr_one;
      w_ras_cnt_next = r_ras_cnt - c_cnt_one;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < c_entries; i++) begin
        r_ctr[i] <= 2'b01;
      end
      r_ras_top <= '0;
      r_ras_cnt <= '0;
    end else begin
      if (w_entry_we) begin
        r_valid[w_uidx] <= 1'b1;
        r_ctr[w_uidx]   <= w_ctr_next;
      end
      r_ras_top <= w_ras_top_next;
      r_ras_cnt <= w_ras_cnt_next;
    end
  end

  // Payload writes during reset are harmless: valid and count are cleared
  always_ff @(posedge clk) begin
    if (w_entry_we) begin
      r_tag[w_uidx]  <= w_utag;
      r_kind[w_uidx] <= bp.upd_kind;
    end
    if (w_tgt_we) begin
      r_target[w_uidx] <= bp.upd_target;
    end
    if (w_ras_we) begin
      r_ras[w_ras_waddr] <= w_link_addr;
    end
  end

endmodule
`default_nettype wire
